// File: rtl/wb_copy_master.sv
// Wishbone classic-cycle block copier: each word is one read, a one-cycle gap, one write, then another gap.
// Define WB_COPY_TIMEOUT_EN to abort a phase that waits TIMEOUT_CYCLES cycles without an ack.
module wb_copy_master #(
    parameter int LEN_W          = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             start_i,
    input  logic [31:0]      src_adr_i,
    input  logic [31:0]      dst_adr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [LEN_W-1:0] count_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic [31:0]      wbm_dat_i,
    input  logic             wbm_ack_i
);

    typedef enum logic [2:0] {IDLE, READ, RGAP, WRITE, WGAP} state_t;

    state_t           state_reg;
    logic [29:0]      src_reg;
    logic [29:0]      dst_reg;
    logic [29:0]      adr_reg;
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] count_reg;
    logic [31:0]      hold_reg;
    logic             stb_reg;
    logic             we_reg;
    logic             busy_reg;
    logic             done_reg;

`ifdef WB_COPY_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_reg;
    logic             err_reg;
    assign err_o = err_reg;
`else
    assign err_o = 1'b0;
`endif

    // Byte-offset bits are dropped by design; the parameter is only consumed by the timeout build.
    logic unused_cfg;
    assign unused_cfg = ^{src_adr_i[1:0], dst_adr_i[1:0], (TIMEOUT_CYCLES >= 1)};

    assign wbm_cyc_o = stb_reg;
    assign wbm_stb_o = stb_reg;
    assign wbm_we_o  = we_reg;
    assign wbm_sel_o = {4{stb_reg}};
    assign wbm_adr_o = {adr_reg, 2'b00};
    assign wbm_dat_o = hold_reg;
    assign busy_o    = busy_reg;
    assign done_o    = done_reg;
    assign count_o   = count_reg;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_reg <= IDLE;
            src_reg   <= '0;
            dst_reg   <= '0;
            adr_reg   <= '0;
            len_reg   <= '0;
            count_reg <= '0;
            hold_reg  <= '0;
            stb_reg   <= 1'b0;
            we_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
`ifdef WB_COPY_TIMEOUT_EN
            tmo_reg   <= '0;
            err_reg   <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        src_reg   <= src_adr_i[31:2];
                        dst_reg   <= dst_adr_i[31:2];
                        len_reg   <= len_i;
                        count_reg <= '0;
`ifdef WB_COPY_TIMEOUT_EN
                        err_reg   <= 1'b0;
                        tmo_reg   <= '0;
`endif
                        if (len_i == '0) begin
                            done_reg <= 1'b1;
                        end else begin
                            state_reg <= READ;
                            stb_reg   <= 1'b1;
                            we_reg    <= 1'b0;
                            adr_reg   <= src_adr_i[31:2];
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (wbm_ack_i) begin
                        hold_reg  <= wbm_dat_i;
                        src_reg   <= src_reg + 30'd1;
                        stb_reg   <= 1'b0;
                        state_reg <= RGAP;
                    end
                end
                RGAP: begin
                    state_reg <= WRITE;
                    stb_reg   <= 1'b1;
                    we_reg    <= 1'b1;
                    adr_reg   <= dst_reg;
`ifdef WB_COPY_TIMEOUT_EN
                    tmo_reg   <= '0;
`endif
                end
                WRITE: begin
                    if (wbm_ack_i) begin
                        dst_reg   <= dst_reg + 30'd1;
                        count_reg <= count_reg + LEN_W'(1);
                        stb_reg   <= 1'b0;
                        we_reg    <= 1'b0;
                        state_reg <= WGAP;
                    end
                end
                WGAP: begin
                    if (count_reg == len_reg) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg <= READ;
                        stb_reg   <= 1'b1;
                        adr_reg   <= src_reg;
`ifdef WB_COPY_TIMEOUT_EN
                        tmo_reg   <= '0;
`endif
                    end
                end
                default: state_reg <= IDLE;
            endcase
`ifdef WB_COPY_TIMEOUT_EN
            // Abort overrides the phase logic above when the wait budget runs out.
            if (state_reg == READ || state_reg == WRITE) begin
                if (wbm_ack_i) begin
                    tmo_reg <= '0;
                end else if (tmo_reg == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_reg <= IDLE;
                    stb_reg   <= 1'b0;
                    we_reg    <= 1'b0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    err_reg   <= 1'b1;
                end else begin
                    tmo_reg <= tmo_reg + 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_wb_copy_master.sv
// Directed bench for wb_copy_master with a latency-configurable Wishbone memory slave.
module tb_wb_copy_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src = '0;
    logic [31:0] dst = '0;
    logic [15:0] len = '0;
    logic        busy_o, done_o, err_o;
    logic [15:0] count_o;
    logic        cyc_o, stb_o, we_o;
    logic [3:0]  sel_o;
    logic [31:0] adr_o, dat_o, dat_i;
    logic        ack_i;

    always #5 clk = ~clk;

    wb_copy_master #(.LEN_W(16), .TIMEOUT_CYCLES(8)) dut (
        .wb_clk_i (clk),     .wb_rst_ni(rst_n),   .start_i  (start),
        .src_adr_i(src),     .dst_adr_i(dst),     .len_i    (len),
        .busy_o   (busy_o),  .done_o   (done_o),  .err_o    (err_o),
        .count_o  (count_o), .wbm_cyc_o(cyc_o),   .wbm_stb_o(stb_o),
        .wbm_we_o (we_o),    .wbm_sel_o(sel_o),   .wbm_adr_o(adr_o),
        .wbm_dat_o(dat_o),   .wbm_dat_i(dat_i),   .wbm_ack_i(ack_i)
    );

    // Slave: 256-word memory, ack after rd_lat/wr_lat wait cycles (0 = same cycle).
    logic [31:0] mem [0:255];
    int          rd_lat = 0;
    int          wr_lat = 0;
    logic        no_ack = 1'b0;
    int          wcnt = 0;
    logic        pl_en = 1'b0;
    logic [7:0]  pl_idx = '0;
    logic [31:0] pl_dat = '0;

    assign ack_i = stb_o && !no_ack && (wcnt == (we_o ? wr_lat : rd_lat));
    assign dat_i = mem[adr_o[9:2]];

    // Bus monitor state (written only here; the stimulus reads deltas).
    logic        last_stb = 1'b0;
    logic        last_ack = 1'b0;
    int          n_bus = 0;
    logic [31:0] rd_last = '0;
    logic [31:0] rd_prev = '0;
    int          cyc_hi = 0, busy_hi = 0, stb_hi = 0;
    int          adr_err = 0, sel_err = 0, drop_err = 0, b2b_err = 0;

    always @(posedge clk) begin
        wcnt <= (!stb_o || ack_i) ? 0 : wcnt + 1;
        if (pl_en) mem[pl_idx] <= pl_dat;
        else if (stb_o && we_o && ack_i) mem[adr_o[9:2]] <= dat_o;
        last_stb <= stb_o;
        last_ack <= stb_o && ack_i;
        if (stb_o && ack_i) n_bus <= n_bus + 1;
        if (stb_o && !we_o && ack_i) begin
            rd_prev <= rd_last;
            rd_last <= adr_o;
        end
    end

    always @(negedge clk) begin
        if (cyc_o) cyc_hi++;
        if (busy_o) busy_hi++;
        if (stb_o) stb_hi++;
        if (stb_o && adr_o[1:0] != 2'b00) adr_err++;
        if ((cyc_o !== stb_o) || (stb_o ? sel_o !== 4'hF : sel_o !== 4'h0)) sel_err++;
        if (last_stb && !last_ack && !stb_o) drop_err++;
        if (last_ack && stb_o) b2b_err++;
    end

    int nerr = 0;
    int nchk = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [7:0] idx, input logic [31:0] val);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_dat = val;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic kick(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        @(negedge clk);
        start = 1'b1; src = s; dst = d; len = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    // lat = number of clock edges from the start-accepting edge to the first cycle with done high.
    task automatic run_copy(input string tag, input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] n, output int lat);
        kick(s, d, n);
        lat = 1;
        while (!done_o && lat < 500) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_done_seen"}, done_o, 1'b1);
        $display("copy %s src=%08h dst=%08h len=%0d done_after=%0d count=%0d err=%0b",
                 tag, s, d, n, lat, count_o, err_o);
    endtask

    int lat;
    int b_bus, b_cyc, b_busy, b_stb, b_drop, b_b2b;

    initial begin
        repeat (2) @(negedge clk);
        check("reset_ctrl", {cyc_o, stb_o, we_o, sel_o, busy_o, done_o, err_o}, 10'h0);
        check("reset_count", count_o, 16'h0);
        rst_n = 1'b1;

        // Zero-wait copy of three words.
        poke(8'd64, 32'hAAAA_0001);
        poke(8'd65, 32'hBBBB_0002);
        poke(8'd66, 32'hCCCC_0003);
        b_bus = n_bus; b_b2b = b2b_err;
        run_copy("zw3", 32'h100, 32'h200, 16'd3, lat);
        check("zw3_latency", lat, 13);
        check("zw3_count", count_o, 16'd3);
        check("zw3_busy_at_done", busy_o, 1'b0);
        check("zw3_bus_cycles", n_bus - b_bus, 6);
        check("zw3_gaps", b2b_err - b_b2b, 0);
        check("zw3_w0", mem[128], 32'hAAAA_0001);
        check("zw3_w1", mem[129], 32'hBBBB_0002);
        check("zw3_w2", mem[130], 32'hCCCC_0003);
        @(negedge clk);
        check("zw3_done_pulse", done_o, 1'b0);

        // Zero-length request issues no bus traffic.
        b_cyc = cyc_hi; b_busy = busy_hi;
        run_copy("len0", 32'h100, 32'h200, 16'd0, lat);
        check("len0_latency", lat, 1);
        repeat (3) @(negedge clk);
        check("len0_cyc_never", cyc_hi - b_cyc, 0);
        check("len0_busy_never", busy_hi - b_busy, 0);

        // SRAM-style slave: read ack after 2 waits, write ack after 1; a stray start mid-copy.
        poke(8'd192, 32'h1234_5678);
        poke(8'd193, 32'h9ABC_DEF0);
        rd_lat = 2; wr_lat = 1;
        b_drop = drop_err;
        kick(32'h300, 32'h380, 16'd2);
        start = 1'b1; src = 32'h100; dst = 32'h200; len = 16'd1;
        @(negedge clk);
        start = 1'b0;
        lat = 2;
        while (!done_o && lat < 500) begin
            @(negedge clk);
            lat++;
        end
        $display("copy sram2 src=00000300 dst=00000380 len=2 done_after=%0d count=%0d err=%0b",
                 lat, count_o, err_o);
        check("sram2_latency", lat, 15);
        check("sram2_count", count_o, 16'd2);
        check("sram2_err", err_o, 1'b0);
        check("sram2_stb_held", drop_err - b_drop, 0);
        check("sram2_w0", mem[224], 32'h1234_5678);
        check("sram2_w1", mem[225], 32'h9ABC_DEF0);
        rd_lat = 0; wr_lat = 0;

        // Source address wraps past 0xFFFF_FFFC.
        poke(8'd255, 32'hDDDD_0004);
        poke(8'd0, 32'hEEEE_0005);
        run_copy("wrap", 32'hFFFF_FFFC, 32'h240, 16'd2, lat);
        check("wrap_rd0_adr", rd_prev, 32'hFFFF_FFFC);
        check("wrap_rd1_adr", rd_last, 32'h0000_0000);
        check("wrap_w0", mem[144], 32'hDDDD_0004);
        check("wrap_w1", mem[145], 32'hEEEE_0005);

        // Unaligned source is forced to a word address.
        run_copy("unal", 32'h103, 32'h2C3, 16'd1, lat);
        check("unal_rd_adr", rd_last, 32'h100);
        check("unal_w0", mem[176], 32'hAAAA_0001);
        check("adr_low_bits", adr_err, 0);
        check("cyc_stb_sel", sel_err, 0);

        // Asynchronous reset while word 2 of 4 is being written.
        poke(8'd67, 32'hFFFF_0006);
        wr_lat = 3;
        kick(32'h100, 32'h340, 16'd4);
        lat = 0;
        while (!(stb_o && we_o && count_o == 16'd1) && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("rst_reached_write2", {stb_o, we_o, dat_o}, {2'b11, 32'hBBBB_0002});
        rst_n = 1'b0;
        #1;
        check("rst_async_ctrl", {cyc_o, stb_o, we_o, sel_o, busy_o, done_o, err_o}, 10'h0);
        check("rst_async_adr", adr_o, 32'h0);
        check("rst_async_dat", dat_o, 32'h0);
        check("rst_async_count", count_o, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wr_lat = 0;
        run_copy("after_rst", 32'h300, 32'h3C0, 16'd2, lat);
        check("after_rst_latency", lat, 9);
        check("after_rst_w0", mem[240], 32'h1234_5678);
        check("after_rst_w1", mem[241], 32'h9ABC_DEF0);

`ifdef WB_COPY_TIMEOUT_EN
        // Slave never acks: abort after 8 waiting cycles.
        no_ack = 1'b1;
        b_stb = stb_hi;
        run_copy("tmo", 32'h100, 32'h200, 16'd1, lat);
        check("tmo_stb_cycles", stb_hi - b_stb, 8);
        check("tmo_latency", lat, 9);
        check("tmo_err", err_o, 1'b1);
        check("tmo_count", count_o, 16'd0);
        check("tmo_stb_low", stb_o, 1'b0);
        no_ack = 1'b0;
        kick(32'h100, 32'h200, 16'd1);
        check("tmo_err_cleared", err_o, 1'b0);
        repeat (6) @(negedge clk);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
